// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: I/O window, widths, size codes
// and small byte helpers.
package mem_ctrl_pkg;

  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  localparam logic [5:0] SIZE_B = 6'd1;
  localparam logic [5:0] SIZE_H = 6'd2;
  localparam logic [5:0] SIZE_W = 6'd4;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_WRITE = 2'd2} state_e;
  typedef enum logic [1:0] {PORT_FETCH = 2'd0, PORT_LOAD = 2'd1, PORT_STORE = 2'd2} port_e;

  // Unsupported sizes fall back to a full word.
  function automatic logic [2:0] size_len(input logic [5:0] size);
    case (size)
      SIZE_B:  size_len = 3'd1;
      SIZE_H:  size_len = 3'd2;
      SIZE_W:  size_len = 3'd4;
      default: size_len = 3'd4;
    endcase
  endfunction

  function automatic logic in_io(input logic [AW-1:0] addr);
    in_io = (addr >= IO_BASE) && (addr <= IO_BASE + 32'd7);
  endfunction

  function automatic logic [7:0] get_byte(input logic [DW-1:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    get_byte = w[7:0];
      2'd1:    get_byte = w[15:8];
      2'd2:    get_byte = w[23:16];
      2'd3:    get_byte = w[31:24];
      default: get_byte = w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating committed stores, loads and
// instruction fetches onto an 8-bit synchronous RAM with one-cycle read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          in_fetcher_flag,
  input  logic [AW-1:0] in_fetcher_addr,
  output logic          out_fetcher_flag,
  output logic [DW-1:0] out_fetcher_inst,
  input  logic          in_lsb_flag,
  input  logic [5:0]    in_lsb_size,
  input  logic          in_lsb_signed,
  input  logic [AW-1:0] in_lsb_addr,
  output logic          out_lsb_flag,
  output logic [DW-1:0] out_lsb_data,
  input  logic          in_rob_flag,
  input  logic [5:0]    in_rob_size,
  input  logic [AW-1:0] in_rob_addr,
  input  logic [DW-1:0] in_rob_data,
  output logic          out_rob_flag,
  input  logic          in_rob_xbp,
  input  logic [7:0]    mem_din,
  output logic [7:0]    mem_dout,
  output logic [AW-1:0] mem_a,
  output logic          mem_wr,
  input  logic          io_buffer_full
);

  state_e        state_q;
  port_e         cur_port_q;
  logic          f_pend_q, l_pend_q, s_pend_q;
  logic [AW-1:0] f_addr_q, l_addr_q, s_addr_q, cur_addr_q;
  logic [2:0]    l_len_q, s_len_q, cur_len_q, cnt_q;
  logic          l_signed_q, cur_signed_q;
  logic [DW-1:0] s_data_q, cur_data_q, buf_q;

  logic          idle_free_s, start_store_s, start_load_s, start_fetch_s;
  logic [DW-1:0] buf_next_s, lsb_word_s;

  // A store to a full I/O buffer blocks the whole arbiter; the cycle after a
  // write is a bubble so mem_wr drops before anything new is driven.
  always_comb begin
    idle_free_s   = (state_q == ST_IDLE) && !mem_wr;
    start_store_s = idle_free_s && s_pend_q && !(in_io(s_addr_q) && io_buffer_full);
    start_load_s  = idle_free_s && !s_pend_q && l_pend_q && !in_rob_xbp;
    start_fetch_s = idle_free_s && !s_pend_q && !l_pend_q && f_pend_q && !in_rob_xbp;
  end

  // Byte cnt-2 arrives on mem_din this cycle; merge it little-endian.
  always_comb begin
    buf_next_s = buf_q;
    case (cnt_q)
      3'd2:    buf_next_s[7:0]   = mem_din;
      3'd3:    buf_next_s[15:8]  = mem_din;
      3'd4:    buf_next_s[23:16] = mem_din;
      3'd5:    buf_next_s[31:24] = mem_din;
      default: buf_next_s = buf_q;
    endcase
  end

  // Sign- or zero-extend narrow loads.
  always_comb begin
    case (cur_len_q)
      3'd1:    lsb_word_s = {{24{cur_signed_q & buf_next_s[7]}}, buf_next_s[7:0]};
      3'd2:    lsb_word_s = {{16{cur_signed_q & buf_next_s[15]}}, buf_next_s[15:0]};
      default: lsb_word_s = buf_next_s;
    endcase
  end

  // Request latching, arbitration and the byte-serial transfer FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;       cur_port_q <= PORT_FETCH;
      f_pend_q <= 1'b0;         l_pend_q <= 1'b0;         s_pend_q <= 1'b0;
      f_addr_q <= '0;           l_addr_q <= '0;           s_addr_q <= '0;
      l_len_q <= 3'd0;          s_len_q <= 3'd0;          cur_len_q <= 3'd0;
      l_signed_q <= 1'b0;       cur_signed_q <= 1'b0;     cnt_q <= 3'd0;
      s_data_q <= '0;           cur_data_q <= '0;         cur_addr_q <= '0;
      buf_q <= '0;
      out_fetcher_flag <= 1'b0; out_fetcher_inst <= '0;
      out_lsb_flag <= 1'b0;     out_lsb_data <= '0;       out_rob_flag <= 1'b0;
      mem_dout <= 8'h00;        mem_a <= '0;              mem_wr <= 1'b0;
    end else if (rdy) begin
      out_fetcher_flag <= 1'b0;
      out_lsb_flag     <= 1'b0;
      out_rob_flag     <= 1'b0;

      if (in_rob_flag) begin
        s_pend_q <= 1'b1;
        s_addr_q <= in_rob_addr;
        s_len_q  <= size_len(in_rob_size);
        s_data_q <= in_rob_data;
      end else if (start_store_s) begin
        s_pend_q <= 1'b0;
      end else begin
        s_pend_q <= s_pend_q;
      end

      if (in_rob_xbp) begin
        l_pend_q <= 1'b0;
      end else if (in_lsb_flag) begin
        l_pend_q   <= 1'b1;
        l_addr_q   <= in_lsb_addr;
        l_len_q    <= size_len(in_lsb_size);
        l_signed_q <= in_lsb_signed;
      end else if (start_load_s) begin
        l_pend_q <= 1'b0;
      end else begin
        l_pend_q <= l_pend_q;
      end

      if (in_rob_xbp) begin
        f_pend_q <= 1'b0;
      end else if (in_fetcher_flag) begin
        f_pend_q <= 1'b1;
        f_addr_q <= in_fetcher_addr;
      end else if (start_fetch_s) begin
        f_pend_q <= 1'b0;
      end else begin
        f_pend_q <= f_pend_q;
      end

      case (state_q)
        ST_IDLE: begin
          mem_a    <= '0;
          mem_dout <= 8'h00;
          mem_wr   <= 1'b0;
          cnt_q    <= 3'd1;
          buf_q    <= '0;
          if (start_store_s) begin
            cur_port_q <= PORT_STORE;
            cur_addr_q <= s_addr_q;
            cur_len_q  <= s_len_q;
            cur_data_q <= s_data_q;
            mem_a      <= s_addr_q;
            mem_dout   <= s_data_q[7:0];
            mem_wr     <= 1'b1;
            if (s_len_q == 3'd1) out_rob_flag <= 1'b1;
            else                 state_q <= ST_WRITE;
          end else if (start_load_s) begin
            cur_port_q   <= PORT_LOAD;
            cur_addr_q   <= l_addr_q;
            cur_len_q    <= l_len_q;
            cur_signed_q <= l_signed_q;
            mem_a        <= l_addr_q;
            state_q      <= ST_READ;
          end else if (start_fetch_s) begin
            cur_port_q   <= PORT_FETCH;
            cur_addr_q   <= f_addr_q;
            cur_len_q    <= 3'd4;
            cur_signed_q <= 1'b0;
            mem_a        <= f_addr_q;
            state_q      <= ST_READ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          mem_a    <= cur_addr_q + {29'd0, cnt_q};
          mem_dout <= get_byte(cur_data_q, cnt_q[1:0]);
          mem_wr   <= 1'b1;
          cnt_q    <= cnt_q + 3'd1;
          if (cnt_q == cur_len_q - 3'd1) begin
            out_rob_flag <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            state_q <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (in_rob_xbp) begin
            state_q <= ST_IDLE;
            mem_a   <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q < cur_len_q) mem_a <= cur_addr_q + {29'd0, cnt_q};
            else                   mem_a <= mem_a;
            if (cnt_q >= 3'd2) buf_q <= buf_next_s;
            else               buf_q <= buf_q;
            if (cnt_q == cur_len_q + 3'd1) begin
              state_q <= ST_IDLE;
              mem_a   <= '0;
              if (cur_port_q == PORT_LOAD) begin
                out_lsb_flag <= 1'b1;
                out_lsb_data <= lsb_word_s;
              end else begin
                out_fetcher_flag <= 1'b1;
                out_fetcher_inst <= buf_next_s;
              end
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of load/fetch vectors plus hand-written
// sequences for arbitration, I/O back-pressure, flush, freeze and reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        in_fetcher_flag = 1'b0;
  logic [31:0] in_fetcher_addr = 32'h0;
  logic        out_fetcher_flag;
  logic [31:0] out_fetcher_inst;
  logic        in_lsb_flag = 1'b0;
  logic [5:0]  in_lsb_size = 6'd0;
  logic        in_lsb_signed = 1'b0;
  logic [31:0] in_lsb_addr = 32'h0;
  logic        out_lsb_flag;
  logic [31:0] out_lsb_data;
  logic        in_rob_flag = 1'b0;
  logic [5:0]  in_rob_size = 6'd0;
  logic [31:0] in_rob_addr = 32'h0;
  logic [31:0] in_rob_data = 32'h0;
  logic        out_rob_flag;
  logic        in_rob_xbp = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [0:4095];
  logic [31:0] log_addr [$];
  logic [7:0]  log_data [$];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetcher_flag(in_fetcher_flag), .in_fetcher_addr(in_fetcher_addr),
    .out_fetcher_flag(out_fetcher_flag), .out_fetcher_inst(out_fetcher_inst),
    .in_lsb_flag(in_lsb_flag), .in_lsb_size(in_lsb_size), .in_lsb_signed(in_lsb_signed),
    .in_lsb_addr(in_lsb_addr), .out_lsb_flag(out_lsb_flag), .out_lsb_data(out_lsb_data),
    .in_rob_flag(in_rob_flag), .in_rob_size(in_rob_size), .in_rob_addr(in_rob_addr),
    .in_rob_data(in_rob_data), .out_rob_flag(out_rob_flag), .in_rob_xbp(in_rob_xbp),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency; contents reloaded while in reset.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22; ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
      ram[12'h200] <= 8'h80;
      ram[12'h300] <= 8'h01; ram[12'h301] <= 8'hF0;
      ram[12'h500] <= 8'h13; ram[12'h501] <= 8'h05; ram[12'h502] <= 8'h00; ram[12'h503] <= 8'h00;
    end else begin
      if (mem_wr) begin
        ram[mem_a[11:0]] <= mem_dout;
        log_addr.push_back(mem_a);
        log_data.push_back(mem_dout);
      end
      mem_din <= ram[mem_a[11:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic f, input logic l, input logic s,
                       input logic [5:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    in_fetcher_flag = f; in_fetcher_addr = addr;
    in_lsb_flag = l; in_lsb_size = size; in_lsb_signed = sgn; in_lsb_addr = addr;
    in_rob_flag = s; in_rob_size = size; in_rob_addr = addr; in_rob_data = data;
    @(posedge clk); #1;
    in_fetcher_flag = 1'b0; in_lsb_flag = 1'b0; in_rob_flag = 1'b0;
  endtask

  function automatic logic sel_flag(input int which);
    case (which)
      0:       sel_flag = out_lsb_flag;
      1:       sel_flag = out_fetcher_flag;
      default: sel_flag = out_rob_flag;
    endcase
  endfunction

  // Counts edges until the chosen completion flag is seen; -1 if the budget expires.
  task automatic wait_flag(input int which, input int maxc, output int k);
    k = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk); #1;
      if (sel_flag(which)) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct {
    int          kind;   // 0 load, 1 fetch
    logic [5:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] exp;
    int          lat;    // edges from request edge to flag
  } vec_t;

  vec_t vecs [8];

  initial begin
    int k, ks, kl, kf, ns, nl, nf, wr_seen, stray;
    logic [31:0] d_lsb, d_fet;

    vecs[0] = '{0, 6'd4, 1'b0, 32'h0000_0100, 32'h4433_2211, 6};
    vecs[1] = '{0, 6'd1, 1'b1, 32'h0000_0200, 32'hFFFF_FF80, 3};
    vecs[2] = '{0, 6'd1, 1'b0, 32'h0000_0200, 32'h0000_0080, 3};
    vecs[3] = '{0, 6'd2, 1'b1, 32'h0000_0300, 32'hFFFF_F001, 4};
    vecs[4] = '{0, 6'd2, 1'b0, 32'h0000_0300, 32'h0000_F001, 4};
    vecs[5] = '{0, 6'd2, 1'b1, 32'h0000_0102, 32'h0000_4433, 4};
    vecs[6] = '{0, 6'd3, 1'b1, 32'h0000_0100, 32'h4433_2211, 6};
    vecs[7] = '{1, 6'd0, 1'b0, 32'h0000_0500, 32'h0000_0513, 6};

    repeat (3) @(posedge clk);
    #1;
    check("reset_lsb_flag", {31'd0, out_lsb_flag}, 32'd0);
    check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("reset_mem_a", mem_a, 32'd0);
    check("reset_lsb_data", out_lsb_data, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      pulse(vecs[i].kind == 1, vecs[i].kind == 0, 1'b0, vecs[i].size, vecs[i].sgn, vecs[i].addr, 32'h0);
      wait_flag(vecs[i].kind, 20, k);
      check($sformatf("vec%0d_latency", i), k, vecs[i].lat);
      check($sformatf("vec%0d_data", i), vecs[i].kind == 1 ? out_fetcher_inst : out_lsb_data, vecs[i].exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d_one_cycle", i), {31'd0, sel_flag(vecs[i].kind)}, 32'd0);
    end

    // Plain SW then a held result check.
    log_addr.delete(); log_data.delete();
    pulse(1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 32'h0000_0400, 32'h1234_5678);
    wait_flag(2, 20, k);
    check("sw_latency", k, 4);
    @(posedge clk); #1;
    check("sw_mem_wr_low", {31'd0, mem_wr}, 32'd0);
    check("sw_log_len", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      check("sw_b0", {log_addr[0][15:0], 8'h00, log_data[0]}, 32'h0400_0078);
      check("sw_b3", {log_addr[3][15:0], 8'h00, log_data[3]}, 32'h0403_0012);
    end
    check("lsb_data_held", out_lsb_data, 32'h4433_2211);

    // Simultaneous store/load/fetch.
    ks = -1; kl = -1; kf = -1; ns = 0; nl = 0; nf = 0;
    @(negedge clk);
    in_rob_flag = 1'b1; in_rob_size = 6'd4; in_rob_addr = 32'h408; in_rob_data = 32'h0102_0304;
    in_lsb_flag = 1'b1; in_lsb_size = 6'd4; in_lsb_signed = 1'b0; in_lsb_addr = 32'h100;
    in_fetcher_flag = 1'b1; in_fetcher_addr = 32'h500;
    @(posedge clk); #1;
    in_rob_flag = 1'b0; in_lsb_flag = 1'b0; in_fetcher_flag = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (out_rob_flag) begin ns++; if (ks < 0) ks = i; end
      if (out_lsb_flag) begin nl++; if (kl < 0) kl = i; end
      if (out_fetcher_flag) begin nf++; if (kf < 0) kf = i; end
    end
    check("prio_store_k", ks, 4);
    check("prio_load_k", kl, 11);
    check("prio_fetch_k", kf, 17);
    check("prio_counts", {ns[7:0], nl[7:0], nf[7:0]}, 32'h0001_0101);
    check("prio_load_data", out_lsb_data, 32'h4433_2211);
    check("prio_fetch_data", out_fetcher_inst, 32'h0000_0513);

    // Store into a full I/O buffer waits.
    log_addr.delete(); log_data.delete();
    io_buffer_full = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 32'h0003_0000, 32'hDEAD_BEEF);
    wr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_wr || out_rob_flag) wr_seen++;
    end
    check("io_stall_no_write", wr_seen, 0);
    io_buffer_full = 1'b0;
    wait_flag(2, 20, k);
    check("io_latency", k, 4);
    @(posedge clk); #1;
    check("io_log_len", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      check("io_b0", log_addr[0], 32'h0003_0000); check("io_d0", log_data[0], 32'hEF);
      check("io_d1", log_data[1], 32'hBE);        check("io_d2", log_data[2], 32'hAD);
      check("io_b3", log_addr[3], 32'h0003_0003); check("io_d3", log_data[3], 32'hDE);
    end

    // Flush during LW byte 2.
    pulse(1'b0, 1'b1, 1'b0, 6'd4, 1'b0, 32'h100, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("xbp_pre_addr", mem_a, 32'h101);
    in_rob_xbp = 1'b1;
    @(posedge clk); #1;
    in_rob_xbp = 1'b0;
    check("xbp_idle_addr", mem_a, 32'h0);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_lsb_flag || mem_a != 32'h0) stray++;
    end
    check("xbp_no_load", stray, 0);

    // Flush during SW leaves the write alone.
    pulse(1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 32'h40C, 32'hCAFE_F00D);
    in_rob_xbp = 1'b1;
    wait_flag(2, 20, k);
    in_rob_xbp = 1'b0;
    check("xbp_sw_latency", k, 4);
    @(posedge clk); #1;

    // Freeze mid-read.
    pulse(1'b0, 1'b1, 1'b0, 6'd4, 1'b0, 32'h100, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy = 1'b0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_lsb_flag || mem_a != 32'h101) stray++;
    end
    check("rdy_hold", stray, 0);
    rdy = 1'b1;
    wait_flag(0, 20, k);
    check("rdy_resume_k", k, 4);
    @(posedge clk); #1;

    // Reset in the middle of a load.
    pulse(1'b0, 1'b1, 1'b0, 6'd4, 1'b0, 32'h100, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    d_lsb = out_lsb_data; d_fet = out_fetcher_inst;
    check("rst_async_addr", mem_a, 32'h0);
    check("rst_async_data", d_lsb | d_fet, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_lsb_flag || out_fetcher_flag || out_rob_flag || mem_wr) stray++;
    end
    check("rst_no_completion", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 IO_BASE, 32'h30000, base of 8-byte I/O window [IO_BASE, IO_BASE+7].
REQ-002 clk  input  1  system clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 rdy  input  1  global enable; 0 freezes block.
REQ-005 in_fetcher_flag  input  1  instruction fetch request.
REQ-006 in_fetcher_addr  input  32  fetch byte address.
REQ-007 out_fetcher_flag  output  1  one-cycle fetch completion.
REQ-008 out_fetcher_inst  output  32  fetched word.
REQ-009 in_lsb_flag  input  1  one-cycle load request pulse from LSB.
REQ-010 in_lsb_size  input  6  load bytes: 1, 2 or 4.
REQ-011 in_lsb_signed  input  1  1 sign-extend, 0 zero-extend.
REQ-012 in_lsb_addr  input  32  load byte address.
REQ-013 out_lsb_flag  output  1  one-cycle load completion.
REQ-014 out_lsb_data  output  32  extended load result.
REQ-015 in_rob_flag  input  1  one-cycle committed-store pulse.
REQ-016 in_rob_size  input  6  store bytes: 1, 2 or 4.
REQ-017 in_rob_addr / in_rob_data  input  32 / 32  store address / data.
REQ-018 out_rob_flag  output  1  one-cycle store completion.
REQ-019 in_rob_xbp  input  1  branch mispredict flush.
REQ-020 mem_din  input  8  RAM read byte.
REQ-021 mem_dout / mem_a / mem_wr  output  8 / 32 / 1  RAM write byte / address / write enable.
REQ-022 io_buffer_full  input  1  I/O output buffer full.

Function
REQ-023 Each port SHALL own a pending bit plus latched fields, set on its flag, cleared at service start; a flag coinciding with that port's completion SHALL be latched.
REQ-024 States IDLE, READ, WRITE; from IDLE at most one transaction starts per edge, priority store > load > fetch; READ/WRITE return to IDLE on last byte.
REQ-025 Read: address addr+k driven on mem_a at start edge + k (k = 0..n-1), mem_wr=0; byte k captured from mem_din at start edge + k + 2; bytes assembled little-endian.
REQ-026 Read completion flag SHALL be high exactly one cycle following start edge + n + 1 (LB: +2, LW: +5).
REQ-027 Load sizes 1/2 SHALL sign- or zero-extend per latched signed; fetch is always 4 bytes unextended.
REQ-028 Write: byte k of data on mem_dout, addr+k on mem_a, mem_wr=1 at start edge + k; out_rob_flag one cycle after start edge + n - 1; mem_wr=0 from next edge.
REQ-029 Store to I/O window while io_buffer_full=1 SHALL not start; FSM stays IDLE serving nothing until full deasserts.
REQ-030 Size not in {1,2,4} SHALL be treated as 4.
REQ-031 In IDLE, mem_wr=0, mem_a=0, mem_dout=0.
REQ-032 in_rob_xbp=1 with rdy=1: READ aborts to IDLE without completion pulse; load/fetch pending cleared; WRITE and store pending unaffected.
REQ-033 rdy=0: all registers hold, including counters and RAM outputs.
REQ-034 Completion data outputs SHALL hold until next completion of same port.

Reset
REQ-035 rst=0 asynchronously: state IDLE, all pending bits and counters 0, every output 0.
REQ-036 Reset mid-transaction SHALL discard it with no completion pulse after release.

Structure
REQ-037 IO_BASE, data/address widths and size encodings SHALL live in the shared definition package; no sub-module, arbitration and byte FSM inline.

Verification
REQ-038 LW addr 0x100, RAM bytes 11 22 33 44 -> out_lsb_data 0x44332211, flag one cycle after start edge + 5.
REQ-039 LB signed addr 0x200 byte 0x80 -> 0xFFFFFF80; LBU -> 0x00000080.
REQ-040 Store, load, fetch flags same cycle -> store served first, then load, then fetch, each completing once.
REQ-041 SW 0xDEADBEEF to 0x30000 with io_buffer_full=1 for 10 cycles -> mem_wr stays 0, then writes EF BE AD DE at 0x30000..0x30003.
REQ-042 xbp during LW byte 2 -> no out_lsb_flag, IDLE next cycle; xbp during SW -> write completes, out_rob_flag pulses.
